// File: rtl/trace_pkg.sv
// Shared types for the pipeline trace path: retirement record, shadow stage slot, limits.
// Record field widths are fixed here; the tagger's ID_W/CYC_W must match them.
package trace_pkg;

    localparam int unsigned TRACE_ID_W  = 8;
    localparam int unsigned TRACE_CYC_W = 16;

    localparam logic [3:0] STALL_CNT_MAX = 4'd15;
    localparam logic [7:0] DROP_CNT_MAX  = 8'd255;

    typedef struct packed {
        logic [TRACE_ID_W-1:0]  seq_id;
        logic [15:0]            pc;
        logic [15:0]            instr;
        logic [TRACE_CYC_W-1:0] fetch_cyc;
        logic [TRACE_CYC_W-1:0] wb_cyc;
        logic [3:0]             stall_cnt;
        logic                   flushed;
    } trace_rec_t;

    typedef struct packed {
        logic                   v;
        logic [TRACE_ID_W-1:0]  seq_id;
        logic [15:0]            pc;
        logic [15:0]            instr;
        logic [TRACE_CYC_W-1:0] fetch_cyc;
        logic [3:0]             stall_cnt;
    } stage_slot_t;

    function automatic trace_rec_t slot_to_rec(input stage_slot_t s,
                                               input logic [TRACE_CYC_W-1:0] wb_cyc,
                                               input logic flushed);
        trace_rec_t r;
        r.seq_id    = s.seq_id;
        r.pc        = s.pc;
        r.instr     = s.instr;
        r.fetch_cyc = s.fetch_cyc;
        r.wb_cyc    = wb_cyc;
        r.stall_cnt = s.stall_cnt;
        r.flushed   = flushed;
        return r;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through record FIFO; a push while full is taken only if the same edge pops.
module trace_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [Width-1:0]         push_data_i,
    input  logic                     pop_ready_i,
    output logic                     valid_o,
    output logic [Width-1:0]         head_o,
    output logic                     full_o,
    output logic [$clog2(Depth):0]   level_o
);
    localparam int unsigned PtrW = $clog2(Depth);

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    level_q, level_d;
    logic [Width-1:0] mem_q [Depth];
    logic             pop;
    logic             wr_en;

    always_comb begin
        valid_o  = level_q != '0;
        full_o   = level_q == (PtrW+1)'(Depth);
        pop      = valid_o && pop_ready_i;
        wr_en    = push_i && (!full_o || pop);
        wr_ptr_d = wr_en ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (wr_en && !pop) begin
            level_d = level_q + (PtrW+1)'(1);
        end else if (!wr_en && pop) begin
            level_d = level_q - (PtrW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: contents are only observed while level is non-zero.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/pipeline_trace_tagger.sv
// Shadows the IF/ID/EX/MEM/WB pipeline and emits one trace record per retirement.
// Define TRACE_FLUSH_REC_EN to also emit a flushed=1 record for each squashed IF instruction.
module pipeline_trace_tagger
    import trace_pkg::*;
#(
    parameter int unsigned ID_W  = TRACE_ID_W,
    parameter int unsigned CYC_W = TRACE_CYC_W,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     if_valid,
    input  logic [15:0]              if_pc,
    input  logic [15:0]              if_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output trace_rec_t               out_rec,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               drop_cnt,
    output logic                     overflow
);
    stage_slot_t      id_q, id_d, ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [ID_W-1:0]  seq_q, seq_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic             overflow_q, overflow_d;

    logic       ret_push, fl_push, push, pop, full, accept, collide;
    trace_rec_t ret_rec, fl_rec, push_rec;
    logic [1:0] n_drop;
    logic [8:0] drop_sum;

`ifdef TRACE_FLUSH_REC_EN
    assign fl_push = !stall && flush && if_valid;
`else
    assign fl_push = 1'b0;
`endif

    always_comb begin
        id_d  = id_q;
        ex_d  = id_q;
        mem_d = ex_q;
        wb_d  = mem_q;
        seq_d = seq_q;
        cyc_d = cyc_q + CYC_W'(1);

        if (stall) begin
            // Stall wins over flush: ID keeps its instruction and accrues stall cycles.
            if (id_q.v && id_q.stall_cnt != STALL_CNT_MAX) begin
                id_d.stall_cnt = id_q.stall_cnt + 4'd1;
            end
            ex_d = '0;
        end else if (flush) begin
            id_d  = '0;
            seq_d = seq_q + ID_W'(fl_push);
        end else begin
            id_d.v         = if_valid;
            id_d.seq_id    = seq_q;
            id_d.pc        = if_pc;
            id_d.instr     = if_instr;
            id_d.fetch_cyc = cyc_q;
            id_d.stall_cnt = '0;
            seq_d          = seq_q + ID_W'(if_valid);
        end
    end

    always_comb begin
        ret_push = wb_q.v;
        ret_rec  = slot_to_rec(wb_q, cyc_q, 1'b0);

        fl_rec.seq_id    = seq_q;
        fl_rec.pc        = if_pc;
        fl_rec.instr     = if_instr;
        fl_rec.fetch_cyc = cyc_q;
        fl_rec.wb_cyc    = cyc_q;
        fl_rec.stall_cnt = '0;
        fl_rec.flushed   = 1'b1;

        // The FIFO takes one record per edge; a colliding flush record is lost.
        push     = ret_push || fl_push;
        push_rec = ret_push ? ret_rec : fl_rec;
        collide  = ret_push && fl_push;
        pop      = out_valid && out_ready;
        accept   = !full || pop;

        n_drop     = 2'(push && !accept) + 2'(collide);
        drop_sum   = {1'b0, drop_cnt_q} + 9'(n_drop);
        drop_cnt_d = (drop_sum > 9'(DROP_CNT_MAX)) ? DROP_CNT_MAX : drop_sum[7:0];
        overflow_d = overflow_q || (n_drop != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q       <= '0;
            ex_q       <= '0;
            mem_q      <= '0;
            wb_q       <= '0;
            seq_q      <= '0;
            cyc_q      <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            id_q       <= id_d;
            ex_q       <= ex_d;
            mem_q      <= mem_d;
            wb_q       <= wb_d;
            seq_q      <= seq_d;
            cyc_q      <= cyc_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    trace_fifo #(
        .Width ($bits(trace_rec_t)),
        .Depth (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_rec),
        .pop_ready_i (out_ready),
        .valid_o     (out_valid),
        .head_o      (out_rec),
        .full_o      (full),
        .level_o     (level)
    );

    assign drop_cnt = drop_cnt_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_pipeline_trace_tagger.sv
// Directed bench for pipeline_trace_tagger (default build, flush records disabled).
module tb_pipeline_trace_tagger;
    import trace_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        if_valid = 1'b0;
    logic [15:0] if_pc = '0;
    logic [15:0] if_instr = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    trace_rec_t  out_rec;
    logic [3:0]  level;
    logic [7:0]  drop_cnt;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipeline_trace_tagger #(
        .ID_W  (8),
        .CYC_W (16),
        .DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .flush     (flush),
        .if_valid  (if_valid),
        .if_pc     (if_pc),
        .if_instr  (if_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rec   (out_rec),
        .level     (level),
        .drop_cnt  (drop_cnt),
        .overflow  (overflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] pc, input logic st, input logic fl);
        if_valid = v;
        if_pc    = pc;
        if_instr = pc ^ 16'hA5A5;
        stall    = st;
        flush    = fl;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        if_valid = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check_rec(input string tag, input logic [31:0] seq, input logic [31:0] pc,
                             input logic [31:0] fcyc, input logic [31:0] wcyc,
                             input logic [31:0] scnt);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_seq"}, 32'(out_rec.seq_id), seq);
        check_eq({tag, "_pc"}, 32'(out_rec.pc), pc);
        check_eq({tag, "_instr"}, 32'(out_rec.instr), 32'(pc[15:0] ^ 16'hA5A5));
        check_eq({tag, "_fcyc"}, 32'(out_rec.fetch_cyc), fcyc);
        check_eq({tag, "_wcyc"}, 32'(out_rec.wb_cyc), wcyc);
        check_eq({tag, "_stall"}, 32'(out_rec.stall_cnt), scnt);
        check_eq({tag, "_flushed"}, 32'(out_rec.flushed), 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_drop", 32'(drop_cnt), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);

        // Straight-line fetch: records at edges 5,6,7
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 16'h0000, 1'b0, 1'b0);
        drive(1'b1, 16'h0002, 1'b0, 1'b0);
        drive(1'b1, 16'h0004, 1'b0, 1'b0);
        idle(1);
        check_eq("t1_latency", 32'(out_valid), 32'd0);
        idle(1);
        check_rec("t1_r0", 0, 16'h0000, 0, 4, 0);
        idle(1);
        check_rec("t1_r1", 1, 16'h0002, 1, 5, 0);
        idle(1);
        check_rec("t1_r2", 2, 16'h0004, 2, 6, 0);
        idle(1);
        check_eq("t1_empty", 32'(out_valid), 32'd0);

        // Three stall cycles with PC 0x0002 in ID
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 16'h0000, 1'b0, 1'b0);
        drive(1'b1, 16'h0002, 1'b0, 1'b0);
        drive(1'b1, 16'h0004, 1'b1, 1'b0);
        drive(1'b1, 16'h0004, 1'b1, 1'b0);
        drive(1'b1, 16'h0004, 1'b1, 1'b0);
        check_rec("t2_r0", 0, 16'h0000, 0, 4, 0);
        drive(1'b1, 16'h0004, 1'b0, 1'b0);
        check_eq("t2_bubble_a", 32'(out_valid), 32'd0);
        idle(2);
        check_eq("t2_bubble_b", 32'(out_valid), 32'd0);
        idle(1);
        check_rec("t2_r1", 1, 16'h0002, 1, 8, 3);
        idle(1);
        check_rec("t2_r2", 2, 16'h0004, 5, 9, 0);

        // Flush squashes PC 0x0010; sequence IDs stay contiguous
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 16'h0000, 1'b0, 1'b0);
        drive(1'b1, 16'h0010, 1'b0, 1'b1);
        drive(1'b1, 16'h0012, 1'b0, 1'b0);
        idle(2);
        check_rec("t3_r0", 0, 16'h0000, 0, 4, 0);
        idle(1);
        check_eq("t3_squashed", 32'(out_valid), 32'd0);
        idle(1);
        check_rec("t3_r1", 1, 16'h0012, 2, 6, 0);

        // Stall and flush together act as stall only
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 16'h0000, 1'b0, 1'b0);
        drive(1'b1, 16'h0002, 1'b1, 1'b1);
        drive(1'b1, 16'h0002, 1'b0, 1'b0);
        idle(2);
        check_eq("t4_delayed", 32'(out_valid), 32'd0);
        idle(1);
        check_rec("t4_r0", 0, 16'h0000, 0, 5, 1);
        idle(1);
        check_rec("t4_r1", 1, 16'h0002, 2, 6, 0);
        check_eq("t4_seq", 32'(dut.seq_q), 32'd2);

        // Backpressure: 10 retirements into an 8-deep FIFO
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) drive(1'b1, 16'(2 * i), 1'b0, 1'b0);
        idle(4);
        check_eq("t5_level", 32'(level), 32'd8);
        check_eq("t5_drop", 32'(drop_cnt), 32'd2);
        check_eq("t5_ovf", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_rec($sformatf("t5_d%0d", i), 32'(i), 32'(2 * i), 32'(i), 32'(i + 4), 0);
            idle(1);
        end
        check_eq("t5_drained", 32'(out_valid), 32'd0);
        check_eq("t5_level0", 32'(level), 32'd0);
        check_eq("t5_ovf_sticky", 32'(overflow), 32'd1);
        check_eq("t5_drop_hold", 32'(drop_cnt), 32'd2);

        // Asynchronous reset mid-stream
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) drive(1'b1, 16'(2 * i), 1'b0, 1'b0);
        idle(4);
        check_eq("t6_level5", 32'(level), 32'd5);
        if_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_valid", 32'(out_valid), 32'd0);
        check_eq("t6_level", 32'(level), 32'd0);
        check_eq("t6_seq", 32'(dut.seq_q), 32'd0);
        check_eq("t6_cyc", 32'(dut.cyc_q), 32'd0);
        check_eq("t6_ovf", 32'(overflow), 32'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 16'h0040, 1'b0, 1'b0);
        idle(4);
        check_rec("t6_r0", 0, 16'h0040, 0, 4, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
